// File: rtl/hex_bcd_display_driver_if.sv
// Bus between the value producer and the HEX display driver.
//   number_in    : 20-bit unsigned value to display (producer -> driver)
//   update       : single-cycle conversion request (producer -> driver)
//   HEX0..HEX5   : active-low 7-segment patterns, bit7 = DP (driver -> pins)
//   driver_ready : 1 = idle with valid HEX outputs, 0 = converting
interface hex_bcd_display_driver_if;
  logic [19:0] number_in;
  logic        update;
  logic [7:0]  HEX0;
  logic [7:0]  HEX1;
  logic [7:0]  HEX2;
  logic [7:0]  HEX3;
  logic [7:0]  HEX4;
  logic [7:0]  HEX5;
  logic        driver_ready;

  modport master (
    output number_in, update,
    input  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, driver_ready
  );

  modport slave (
    input  number_in, update,
    output HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, driver_ready
  );
endinterface

// File: rtl/hex_bcd_display_driver.sv
// Binary (20-bit) to six-digit BCD converter (sequential double-dabble) driving
// six active-low 7-segment displays, HEX0 = units ... HEX5 = hundred-thousands.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : slave side of hex_bcd_display_driver_if (number_in, update in;
//           HEX0..HEX5, driver_ready out, all registered)
// Optional feature: define LEADING_ZERO_BLANK_EN to blank zero digits above the
// most significant non-zero digit (HEX0 always shows a digit).
module hex_bcd_display_driver (
  input  logic                      clk,
  input  logic                      reset,
  hex_bcd_display_driver_if.slave   bus
);

  localparam int unsigned BIN_W    = 20;
  localparam int unsigned DIGITS   = 6;
  localparam int unsigned BCD_W    = 4 * DIGITS;
  localparam int unsigned CNT_W    = 5;
  localparam int unsigned SEG_W    = 8;
  localparam logic [BIN_W-1:0] MAX_VAL  = BIN_W'(999999);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BIN_W - 1);
  localparam logic [SEG_W-1:0] BLANK    = 8'hFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e                        state_q, state_d;
  logic [BIN_W-1:0]              bin_q, bin_d;
  logic [BCD_W-1:0]              bcd_q, bcd_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [DIGITS-1:0][SEG_W-1:0]  hex_q, hex_d;
  logic                          ready_q, ready_d;
  logic [BCD_W-1:0]              adj;

  // BCD nibble to active-low segments, DP off; 10..15 blank
  function automatic logic [SEG_W-1:0] seg_enc(input logic [3:0] nib);
    case (nib)
      4'd0:    seg_enc = 8'hC0;
      4'd1:    seg_enc = 8'hF9;
      4'd2:    seg_enc = 8'hA4;
      4'd3:    seg_enc = 8'hB0;
      4'd4:    seg_enc = 8'h99;
      4'd5:    seg_enc = 8'h92;
      4'd6:    seg_enc = 8'h82;
      4'd7:    seg_enc = 8'hF8;
      4'd8:    seg_enc = 8'h80;
      4'd9:    seg_enc = 8'h98;
      default: seg_enc = BLANK;
    endcase
  endfunction

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      hex_q   <= {DIGITS{BLANK}};
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      hex_q   <= hex_d;
      ready_q <= ready_d;
    end
  end

  // Next-state and datapath logic
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    hex_d   = hex_q;
    ready_d = ready_q;
    adj     = bcd_q;
`ifdef LEADING_ZERO_BLANK_EN
    begin : lzb
      logic lead;
      lead = 1'b1;
`endif

    case (state_q)
      IDLE: begin
        if (bus.update) begin
          bin_d   = (bus.number_in > MAX_VAL) ? MAX_VAL : bus.number_in;
          bcd_d   = '0;
          cnt_d   = '0;
          ready_d = 1'b0;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        // add-3 correction precedes the shift so each nibble stays decimal
        for (int i = 0; i < DIGITS; i++) begin
          if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
        {bcd_d, bin_d} = {adj[BCD_W-2:0], bin_q, 1'b0};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) state_d = DONE;
      end

      DONE: begin
        for (int i = 0; i < DIGITS; i++) hex_d[i] = seg_enc(bcd_q[4*i +: 4]);
`ifdef LEADING_ZERO_BLANK_EN
        for (int i = DIGITS - 1; i > 0; i--) begin
          if (bcd_q[4*i +: 4] != 4'd0) lead = 1'b0;
          if (lead) hex_d[i] = BLANK;
        end
`endif
        ready_d = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
`ifdef LEADING_ZERO_BLANK_EN
    end
`endif
  end

  assign bus.HEX0         = hex_q[0];
  assign bus.HEX1         = hex_q[1];
  assign bus.HEX2         = hex_q[2];
  assign bus.HEX3         = hex_q[3];
  assign bus.HEX4         = hex_q[4];
  assign bus.HEX5         = hex_q[5];
  assign bus.driver_ready = ready_q;

endmodule

// File: tb/tb_hex_bcd_display_driver.sv
// Directed bench for hex_bcd_display_driver (default build, no leading-zero blanking).
module tb_hex_bcd_display_driver;

  typedef struct {
    logic [47:0] hex;
    string       tag;
  } exp_t;

  logic clk;
  logic reset;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   k_edge   = 0;
  exp_t sb[$];
  logic [47:0] last_hex;
  logic [7:0]  seg_tab [10];

  hex_bcd_display_driver_if bif ();

  hex_bcd_display_driver dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [47:0] obs_hex();
    return {bif.HEX5, bif.HEX4, bif.HEX3, bif.HEX2, bif.HEX1, bif.HEX0};
  endfunction

  // Reference: saturate, split into decimal digits, encode each
  function automatic logic [47:0] model(input int unsigned v);
    logic [47:0] r;
    int unsigned x;
    x = (v > 999999) ? 999999 : v;
    for (int i = 0; i < 6; i++) begin
      r[8*i +: 8] = seg_tab[x % 10];
      x = x / 10;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a one-cycle update (or leave it held) and queue the expected display
  task automatic start_conv(input int unsigned v, input logic [47:0] exp,
                            input string tag, input bit hold);
    exp_t e;
    e.hex = exp;
    e.tag = tag;
    sb.push_back(e);
    bif.number_in = 20'(v);
    bif.update    = 1'b1;
    tick();
    k_edge = cyc;
    if (!hold) bif.update = 1'b0;
    chk({tag, "_ready_low"}, 48'(bif.driver_ready), 48'd0);
    chk({tag, "_hex_hold0"}, obs_hex(), last_hex);
  endtask

  // Wait (bounded) for ready, then pop and compare display and latency
  task automatic finish_conv();
    exp_t e;
    e = sb.pop_front();
    while (bif.driver_ready !== 1'b1 && (cyc - k_edge) < 60) begin
      tick();
      if ((cyc - k_edge) == 10) chk({e.tag, "_hex_hold_mid"}, obs_hex(), last_hex);
    end
    chk({e.tag, "_latency"}, 48'(cyc - k_edge), 48'd21);
    chk({e.tag, "_hex"}, obs_hex(), e.hex);
    last_hex = e.hex;
  endtask

  initial begin
    int unsigned r;
    seg_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h98};
    last_hex      = {6{8'hFF}};
    reset         = 1'b0;
    bif.update    = 1'b0;
    bif.number_in = '0;
    repeat (3) tick();
    chk("reset_hex", obs_hex(), {6{8'hFF}});
    chk("reset_ready", 48'(bif.driver_ready), 48'd1);
    reset = 1'b1;
    repeat (2) tick();

    start_conv(55, 48'hC0C0_C0C0_9292, "n55", 1'b0);            finish_conv();
    start_conv(123456, 48'hF9A4_B099_9282, "n123456", 1'b0);    finish_conv();
    start_conv(101010, 48'hF9C0_F9C0_F9C0, "n101010", 1'b0);    finish_conv();
    start_conv(999999, {6{8'h98}}, "n999999", 1'b0);            finish_conv();
    start_conv(1048575, {6{8'h98}}, "sat_max", 1'b0);           finish_conv();
    start_conv(0, {6{8'hC0}}, "zero", 1'b0);                    finish_conv();
    for (int i = 0; i < 3; i++) begin
      r = $urandom_range(0, 1048575);
      start_conv(r, model(r), $sformatf("rnd%0d_%0d", i, r), 1'b0);
      finish_conv();
    end

    // Update mid-conversion must be ignored
    start_conv(777, model(777), "ignore", 1'b0);
    repeat (4) tick();
    bif.number_in = 20'd12;
    bif.update    = 1'b1;
    tick();
    bif.update    = 1'b0;
    chk("ignore_ready_low", 48'(bif.driver_ready), 48'd0);
    finish_conv();
    repeat (3) tick();
    chk("ignore_no_restart", 48'(bif.driver_ready), 48'd1);
    chk("ignore_hex_stable", obs_hex(), model(777));

    // Held update restarts as soon as the FSM is idle again
    start_conv(8, model(8), "held_a", 1'b1);
    finish_conv();
    tick();
    k_edge = cyc;
    chk("held_restart", 48'(bif.driver_ready), 48'd0);
    bif.update = 1'b0;
    sb.push_back('{hex: model(8), tag: "held_b"});
    finish_conv();

    // Asynchronous reset mid-conversion
    start_conv(4321, model(4321), "rst_mid", 1'b0);
    repeat (5) tick();
    #2 reset = 1'b0;
    #1;
    chk("rst_mid_hex", obs_hex(), {6{8'hFF}});
    chk("rst_mid_ready", 48'(bif.driver_ready), 48'd1);
    void'(sb.pop_front());
    last_hex = {6{8'hFF}};
    tick();
    reset = 1'b1;
    tick();
    start_conv(42, model(42), "after_rst", 1'b0);
    finish_conv();

    chk("sb_empty", 48'(sb.size()), 48'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
